// File: rtl/acq_readout_sequencer.sv
// acq_readout_sequencer: arms the ADC waveform generator, steps sample_num through the capture and streams the returned words through a credit-controlled FIFO
module acq_readout_sequencer #(
  parameter int NUM_SAMPLES = 1000,
  parameter int ARM_CYCLES = 64,
  parameter int READ_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  input  logic [2:0]  cfg,
  output logic [7:0]  adc_control,
  output logic [15:0] sample_num,
  input  logic [15:0] wave_sample,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic        done,
  output logic        cmd_rejected,
  output logic        aborted
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, ARM, SETTLE, READ, DRAIN} state_t;
  state_t state;
  logic arm, settle_cnt, iss, can_issue;
  logic [2:0] cfg_q;
  logic [15:0] arm_cnt, cap_cnt, outstanding;
  logic [READ_LAT-1:0] pipe;
  logic [17:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic start, stop, wr, rd;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign start = cmd_valid && cmd_data == 8'h41;
  assign stop = cmd_valid && cmd_data == 8'h53;
  assign busy = state != IDLE;
  assign wr = pipe[READ_LAT-1];
  assign out_valid = fifo_count != '0;
  assign rd = out_valid && out_ready;
  assign {out_eof, out_sof, out_data} = out_valid ? mem[rd_ptr] : '0;
  assign adc_control = {4'b0, cfg_q, arm};
  always_comb begin
    outstanding = {15'b0, iss};
    for (int i = 0; i < READ_LAT; i++) outstanding = outstanding + {15'b0, pipe[i]};
  end
  assign can_issue = {1'b0, outstanding} + 17'(fifo_count) < 17'(FIFO_DEPTH) + 17'(rd);
  always_ff @(posedge sys_clk) begin
    if (wr) mem[wr_ptr] <= {cap_cnt == 16'(NUM_SAMPLES - 1), cap_cnt == 16'd0, wave_sample};
  end
  always_ff @(posedge sys_clk) begin
    if (!reset_n || (stop && busy)) begin
      state <= IDLE;
      arm <= 1'b0;
      arm_cnt <= '0;
      settle_cnt <= 1'b0;
      iss <= 1'b0;
      pipe <= '0;
      sample_num <= '0;
      cap_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      cfg_q <= reset_n ? cfg_q : 3'b0;
      done <= 1'b0;
      cmd_rejected <= 1'b0;
      aborted <= reset_n;
    end else begin
      done <= 1'b0;
      aborted <= 1'b0;
      cmd_rejected <= start && busy;
      iss <= 1'b0;
      pipe <= (pipe << 1) | READ_LAT'(iss);
      fifo_count <= fifo_count + CW'(wr) - CW'(rd);
      if (wr) begin
        wr_ptr <= nxt(wr_ptr);
        cap_cnt <= cap_cnt + 16'd1;
      end
      if (rd) rd_ptr <= nxt(rd_ptr);
      case (state)
        IDLE: if (start) begin
          state <= ARM;
          arm <= 1'b1;
          arm_cnt <= '0;
          cfg_q <= cfg;
          cap_cnt <= '0;
        end
        ARM: if (arm_cnt == 16'(ARM_CYCLES - 1)) begin
          state <= SETTLE;
          arm <= 1'b0;
          settle_cnt <= 1'b0;
        end else arm_cnt <= arm_cnt + 16'd1;
        SETTLE: if (settle_cnt) begin
          state <= READ;
          iss <= 1'b1;
          sample_num <= '0;
        end else settle_cnt <= 1'b1;
        READ: if (sample_num == 16'(NUM_SAMPLES - 1)) state <= DRAIN;
        else if (can_issue) begin
          iss <= 1'b1;
          sample_num <= sample_num + 16'd1;
        end
        DRAIN: if (rd && out_eof) begin
          state <= IDLE;
          done <= 1'b1;
          sample_num <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/acq_readout_sequencer.md
# acq_readout_sequencer

Sequences one acquire-and-readout cycle of the ADC handler per host command. It arms the waveform generator through `adc_control`, waits a settle window, then steps `sample_num` through the captured waveform. Returned `wave_sample` words are buffered in a small credit-controlled FIFO and emitted as a framed valid/ready stream toward the Ethernet packetizer. It sits between the host command decoder and the ADC handler.

## Interface
- `NUM_SAMPLES`, 1000: samples read per waveform; 2..65535.
- `ARM_CYCLES`, 64: cycles `adc_control[0]` is held high; ≥1.
- `READ_LAT`, 2: cycles from `sample_num` change to valid `wave_sample`; ≥1.
- `FIFO_DEPTH`, 4: output buffer words; must be ≥ `READ_LAT`+2 for full throughput.

Ports:
- `sys_clk` in 1: the single clock. All logic is on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: host command byte strobe, one cycle per byte.
- `cmd_data` in 8: command byte. 0x41 'A' = start; 0x53 'S' = abort; all other values are ignored.
- `cfg` in 3: {delay, trigSlope, trigSource}, sampled on the cycle a start is accepted.
- `adc_control` out 8: {4'b0, delay, trigSlope, trigSource, acquireRequest}.
- `sample_num` out 16: sample index driven to the ADC handler.
- `wave_sample` in 16: sample word returned by the ADC handler.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: stream consumer ready.
- `out_data` out 16: stream word.
- `out_sof` out 1: qualifies `out_data` as the word for sample 0.
- `out_eof` out 1: qualifies `out_data` as the word for sample `NUM_SAMPLES`-1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on frame completion.
- `cmd_rejected` out 1: one-cycle pulse when 'A' arrives while busy.
- `aborted` out 1: one-cycle pulse when an abort is taken.

## Operation
- **States:**
  - IDLE: wait for a start command.
  - ARM: hold `adc_control[0]`=1 for `ARM_CYCLES` cycles.
  - SETTLE: 2 cycles with `adc_control[0]`=0, so the sampler latches the new waveform.
  - READ: issue indices.
  - DRAIN: wait for every issued word to be emitted.
- **Transitions:**
  - IDLE→ARM on `cmd_valid` with 0x41. `cfg` is latched into `adc_control[3:1]` at the same time and held until the next start.
  - ARM→SETTLE when the arm counter reaches `ARM_CYCLES`.
  - SETTLE→READ after 2 cycles.
  - READ→DRAIN after index `NUM_SAMPLES`-1 is issued.
  - DRAIN→IDLE on the handshake of the eof word. `done` pulses on the cycle after that handshake.
- **Issue rule:**
  - In READ, an index is issued when `outstanding + fifo_count < FIFO_DEPTH`, where `outstanding` counts issued indices not yet captured.
  - Issuing means `sample_num` takes the next index: 0 on the first issue, then +1.
  - Between issues `sample_num` holds its value. It is 0 in IDLE.
- **Capture:** a `READ_LAT`-deep shift register of issue flags marks when `wave_sample` belongs to an issued index. The word is written to the FIFO on that cycle.
- **Stream:**
  - The FIFO is show-ahead and registered. `out_data`, `out_sof` and `out_eof` come from the head entry, and `out_sof`/`out_eof` are stored with each entry.
  - A word is transferred on `out_valid & out_ready`.
  - `out_valid` stays high and `out_data` stays stable while `out_ready`=0.
- **Abort:**
  - Taken on 'S' in any non-IDLE state.
  - Next cycle: state=IDLE, FIFO and pipeline flushed, `out_valid`=0, `adc_control[0]`=0, `sample_num`=0, `aborted` pulses, no `done`.
  - 'S' in IDLE is ignored, with no pulse.
- **Busy:** 'A' while `busy` gives a `cmd_rejected` pulse and no state change. Bytes other than 0x41/0x53 have no effect in any state.
- **Width rules:** counters are 16-bit. `fifo_count` is clog2(`FIFO_DEPTH`+1) bits.

## Timing
- **Reset values:** all outputs 0, state IDLE, FIFO empty. Reset mid-frame behaves like abort, except `aborted` stays 0.
- **Start accepted at cycle T:**
  - `busy`=1 and `adc_control[0]`=1 from T+1 through T+`ARM_CYCLES`.
  - SETTLE at T+`ARM_CYCLES`+1 and T+`ARM_CYCLES`+2.
  - READ from R = T+`ARM_CYCLES`+3, with `sample_num`=0 driven at R.
- **Latency:** an index issued at cycle X is captured at X+`READ_LAT`. The first `out_valid` is at R+`READ_LAT`+1.
- **Throughput:** with `out_ready`=1 continuously, one word per cycle. The eof handshake is at R+`READ_LAT`+`NUM_SAMPLES`, and `done` follows one cycle later.
- **Backpressure:** with `out_ready`=0, at most `FIFO_DEPTH` words are buffered or in flight. There is no overflow and no word is lost or duplicated.
- **Simultaneous events:**
  - FIFO write and read in the same cycle leave `fifo_count` unchanged.
  - An abort in the same cycle as the eof handshake takes priority, so `aborted` pulses and `done` does not.

## Test plan
- **Nominal frame:** reset, then `cfg`=3'b101 and 'A' at T with `out_ready`=1 and `wave_sample` = index echoed with `READ_LAT` delay. Required: `adc_control` = 0x0B during ARM, 1000 words 0..999 in order, sof on 0, eof on 999, `done` at R+1003.
- **Backpressure:** toggle `out_ready` 1 cycle in 3. Required: the identical 1000-word sequence, `outstanding + fifo_count` never above 4, `out_data` stable while stalled.
- **Busy rejection:** 'A' during READ. Required: one `cmd_rejected` pulse and an unchanged frame.
- **Abort:** 'S' at sample 500. Required: `aborted` pulse, next cycle `out_valid`=0 and `sample_num`=0, no `done`. A new 'A' then gives a full, clean frame.
- **Reset mid-frame:** `reset_n`=0 for 1 cycle during ARM. Required: all outputs 0, state IDLE, no pulses.
- **Ignored bytes:** 0x53 and 0x00 in IDLE. Required: no output change.
